// File: rtl/piso_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module  : piso_frame_serializer
// Brief   : Parallel-in/serial-out framer: start, DATA_W bits LSB-first,
//           optional even parity (macro SER_PARITY_EN), stop. Idle high.
// Revision: 1.0 - initial release
// ============================================================================
module piso_frame_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SER_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cyc, w_cyc_nxt;
  logic [BW-1:0]     r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_serial_out, w_serial_nxt;
  logic              r_in_ready, w_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_frame_done, w_done_nxt;
  logic              w_period_end;
`ifdef SER_PARITY_EN
  logic              r_parity, w_parity_nxt;
`endif

  assign w_period_end = (r_cyc == C_CYC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cyc        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_serial_out <= 1'b1;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cyc        <= w_cyc_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_serial_out <= w_serial_nxt;
      r_in_ready   <= w_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
`ifdef SER_PARITY_EN
      r_parity     <= w_parity_nxt;
`endif
    end
  end

  // Every output is computed one cycle ahead so it can be driven from a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = r_cyc;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_serial_nxt = r_serial_out;
    w_ready_nxt  = r_in_ready;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
`ifdef SER_PARITY_EN
    w_parity_nxt = r_parity;
`endif

    if (r_state != S_IDLE) begin
      w_cyc_nxt = w_period_end ? '0 : r_cyc + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_ready_nxt  = 1'b1;
        w_busy_nxt   = 1'b0;
        w_serial_nxt = 1'b1;
        if (in_valid && r_in_ready) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = in_data;
          w_cyc_nxt    = '0;
          w_bit_nxt    = '0;
          w_serial_nxt = 1'b0;
          w_ready_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
`ifdef SER_PARITY_EN
          w_parity_nxt = ^in_data;
`endif
        end
      end

      S_START: begin
        if (w_period_end) begin
          w_state_nxt  = S_DATA;
          w_bit_nxt    = '0;
          w_serial_nxt = r_shift[0];
          w_shift_nxt  = r_shift >> 1;
        end
      end

      S_DATA: begin
        if (w_period_end) begin
          if (r_bit == C_BIT_LAST) begin
`ifdef SER_PARITY_EN
            w_state_nxt  = S_PARITY;
            w_serial_nxt = r_parity;
`else
            w_state_nxt  = S_STOP;
            w_serial_nxt = 1'b1;
`endif
          end else begin
            w_bit_nxt    = r_bit + 1'b1;
            w_serial_nxt = r_shift[0];
            w_shift_nxt  = r_shift >> 1;
          end
        end
      end

`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (w_period_end) begin
          w_state_nxt  = S_STOP;
          w_serial_nxt = 1'b1;
        end
      end
`endif

      S_STOP: begin
        // Ready rises together with frame_done so a new word can go back-to-back.
        if (w_period_end) begin
          w_state_nxt  = S_IDLE;
          w_serial_nxt = 1'b1;
          w_ready_nxt  = 1'b1;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_serial_nxt = 1'b1;
        w_ready_nxt  = 1'b1;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  assign in_ready   = r_in_ready;
  assign serial_out = r_serial_out;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_frame_serializer.sv
`default_nettype none
// Testbench for piso_frame_serializer: two instances (CLKS_PER_BIT 4 and 1),
// random words scored against a frame model built from the framing rules.
module tb_piso_frame_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid   [2];
  logic [W-1:0] in_data    [2];
  logic         in_ready   [2];
  logic         serial_out [2];
  logic         busy       [2];
  logic         frame_done [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp_v);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int frame_len(input int cpb);
    return (W + 2 + PAR) * cpb;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CPB = (g == 0) ? 4 : 1;
    exp_t exp_q[$];
    logic samples[$];

    piso_frame_serializer #(.DATA_W(W), .CLKS_PER_BIT(CPB)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .serial_out (serial_out[g]),
      .busy       (busy[g]),
      .frame_done (frame_done[g])
    );

    // Handshake observer: a word is taken on the edge after valid&ready is seen.
    always @(negedge clk) begin
      if (rst) exp_q.delete();
      else if (in_valid[g] === 1'b1 && in_ready[g] === 1'b1)
        exp_q.push_back('{d: in_data[g], acc: cyc});
    end

    always @(negedge clk) begin : mon
      exp_t e;
      logic bits[$];
      int   bad;
      if (rst) begin
        samples.delete();
        chk(serial_out[g] === 1'b1 && busy[g] === 1'b0 && in_ready[g] === 1'b1 && frame_done[g] === 1'b0,
            $sformatf("reset_outputs_dut%0d", g),
            int'({serial_out[g], busy[g], in_ready[g], frame_done[g]}), 10);
      end else if (frame_done[g] === 1'b1) begin
        chk(serial_out[g] === 1'b1 && in_ready[g] === 1'b1 && busy[g] === 1'b0,
            $sformatf("done_cycle_outputs_dut%0d", g),
            int'({serial_out[g], busy[g], in_ready[g]}), 5);
        if (exp_q.size() == 0) begin
          chk(1'b0, $sformatf("unexpected_frame_done_dut%0d", g), 1, 0);
        end else begin
          e = exp_q.pop_front();
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < W; i++) bits.push_back(e.d[i]);
`ifdef SER_PARITY_EN
          bits.push_back(^e.d);
`endif
          bits.push_back(1'b1);
          chk(cyc - e.acc - 1 == frame_len(CPB), $sformatf("frame_latency_dut%0d", g),
              cyc - e.acc - 1, frame_len(CPB));
          chk(samples.size() == bits.size() * CPB, $sformatf("stream_length_dut%0d", g),
              samples.size(), bits.size() * CPB);
          bad = 0;
          for (int i = 0; i < samples.size() && i < bits.size() * CPB; i++)
            if (samples[i] !== bits[i / CPB]) bad++;
          chk(bad == 0, $sformatf("stream_bits_dut%0d_word%02h", g, e.d), bad, 0);
        end
        samples.delete();
      end else if (busy[g] === 1'b1) begin
        samples.push_back(serial_out[g]);
        chk(in_ready[g] === 1'b0, $sformatf("busy_not_ready_dut%0d", g), int'(in_ready[g]), 0);
      end else begin
        chk(serial_out[g] === 1'b1 && in_ready[g] === 1'b1 && frame_done[g] === 1'b0,
            $sformatf("idle_outputs_dut%0d", g),
            int'({serial_out[g], in_ready[g], frame_done[g]}), 6);
      end
    end
  end

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input int k, input logic [W-1:0] d, output bit fd_at_acc);
    fd_at_acc   = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready[k] === 1'b1) begin
        fd_at_acc = frame_done[k];
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk(1'b0, $sformatf("accept_timeout_dut%0d", k), 0, 1);
  endtask

  task automatic garbage(input int k);
    for (int t = 0; t < 400; t++) begin
      in_data[k] = W'($urandom);
      @(negedge clk);
      if (in_ready[k] === 1'b1) begin
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    chk(1'b0, $sformatf("garbage_timeout_dut%0d", k), 0, 1);
  endtask

  task automatic wait_idle(input int k);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (busy[k] === 1'b0 && frame_done[k] === 1'b0) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk(1'b0, $sformatf("idle_timeout_dut%0d", k), 0, 1);
  endtask

  task automatic abort_check(input int k, input string name);
    rst = 1'b1;
    #1;
    chk(serial_out[k] === 1'b1 && busy[k] === 1'b0 && in_ready[k] === 1'b1 && frame_done[k] === 1'b0,
        $sformatf("%s_dut%0d", name, k),
        int'({serial_out[k], busy[k], in_ready[k], frame_done[k]}), 10);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_dut(input int k);
    bit fd;
    int cpb;
    cpb = (k == 0) ? 4 : 1;

    send(k, 8'hA5, fd); in_valid[k] = 1'b0; wait_idle(k);
    send(k, 8'h07, fd); in_valid[k] = 1'b0; wait_idle(k);

    send(k, 8'h00, fd);
    send(k, 8'hFF, fd);
    chk(fd, $sformatf("b2b_accept_in_done_cycle_dut%0d", k), int'(fd), 1);
    in_valid[k] = 1'b0;
    wait_idle(k);

    send(k, 8'h3C, fd); garbage(k); wait_idle(k);

    for (int n = 0; n < 10; n++) begin
      send(k, W'($urandom), fd);
      if ($urandom_range(0, 1) == 1) garbage(k);
      else begin
        in_valid[k] = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    end
    wait_idle(k);

    // Abort in the middle of the data bits, then in the start bit.
    send(k, 8'hFF, fd); in_valid[k] = 1'b0;
    repeat (cpb * 3) begin @(posedge clk); #1; end
    abort_check(k, "abort_data");
    send(k, W'($urandom), fd); in_valid[k] = 1'b0;
    abort_check(k, "abort_start");

    send(k, 8'h81, fd); in_valid[k] = 1'b0; wait_idle(k);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end

    for (int k = 0; k < 2; k++) run_dut(k);

    repeat (5) begin @(posedge clk); #1; end
    chk(g_dut[0].exp_q.size() == 0, "pending_frames_dut0", g_dut[0].exp_q.size(), 0);
    chk(g_dut[1].exp_q.size() == 0, "pending_frames_dut1", g_dut[1].exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
